// File: rtl/sht10_if.sv
// SHT10 two-wire link: master SCK, resolved DATA level, slave open-drain pull-down enable.
interface sht10_if;
  logic sck;
  logic sda_in;
  logic sda_out_en;

  modport master (output sck, output sda_in, input sda_out_en);
  modport slave  (input sck, input sda_in, output sda_out_en);
endinterface

// File: rtl/sht10_slave_emulator.sv
// SHT10 sensor-side responder: start/command decode with ACK, conversion delay, data + CRC-8 readout.
// States: IDLE, ST1..ST3 (start sequence), CMD, CMD_ACK, MEAS, SRST, READY, TX, M_ACK.
module sht10_slave_emulator #(
  parameter logic [2:0]  ADDR        = 3'b000,
  parameter int unsigned MEAS_CYCLES = 100000,
  parameter int unsigned SRST_CYCLES = 1100
) (
  input  logic        clock,
  input  logic        reset,
  sht10_if.slave      bus,
  input  logic [13:0] temp_value,
  input  logic [11:0] rh_value,
  output logic        busy,
  output logic [4:0]  last_cmd,
  output logic        frame_error
);

  localparam int unsigned TMAX = (MEAS_CYCLES > SRST_CYCLES) ? MEAS_CYCLES : SRST_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [4:0] CMD_TEMP = 5'b00011;
  localparam logic [4:0] CMD_RH   = 5'b00101;
  localparam logic [4:0] CMD_STAT = 5'b00111;
  localparam logic [4:0] CMD_SRST = 5'b11110;

  typedef enum logic [3:0] {
    IDLE, ST1, ST2, ST3, CMD, CMD_ACK, MEAS, SRST, READY, TX, M_ACK
  } state_t;

  state_t         state;
  logic           sck_meta, sck_sync, sck_prev;
  logic           sda_meta, sda_sync, sda_prev;
  logic           sda_drive;
  logic [7:0]     status;
  logic [7:0]     shift;
  logic [2:0]     bit_cnt;
  logic [1:0]     byte_cnt;
  logic [1:0]     last_byte;
  logic           phase;
  logic [TW-1:0]  timer;
  logic [7:0]     crc;
  logic [15:0]    word;
  logic [23:0]    tx_shift;
  logic [4:0]     cmd_code;
  logic [3:0]     conn_cnt;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[7] ^ d[i]) r = {r[6:0], 1'b0} ^ 8'h31;
      else             r = {r[6:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  logic       sck_rise, sck_fall, sda_rise, sda_fall;
  logic [7:0] cmd_byte;
  logic       cmd_ok;
  logic       abort_start;
  logic       conn_hit;
  logic [7:0] crc_init;
  logic [7:0] crc_stat;
  logic [7:0] crc_word;

  assign sck_rise    = sck_sync & ~sck_prev;
  assign sck_fall    = ~sck_sync & sck_prev;
  assign sda_rise    = sda_sync & ~sda_prev;
  assign sda_fall    = ~sda_sync & sda_prev;
  assign cmd_byte    = {shift[6:0], sda_sync};
  assign cmd_ok      = (cmd_byte[7:5] == ADDR) &&
                       (cmd_byte[4:0] == CMD_TEMP || cmd_byte[4:0] == CMD_RH ||
                        cmd_byte[4:0] == CMD_STAT || cmd_byte[4:0] == CMD_SRST);
  // a start seen while we are not pulling DATA low can only come from the master
  assign abort_start = sda_fall & sck_sync & ~sda_drive;
  assign conn_hit    = sck_rise & sda_sync & ~sda_drive & (conn_cnt == 4'd8);
  assign crc_init    = {status[0], status[1], status[2], status[3], 4'h0};
  assign crc_stat    = crc8(crc, status);
  assign crc_word    = crc8(crc8(crc, word[15:8]), word[7:0]);
  assign bus.sda_out_en = sda_drive;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      sck_meta    <= 1'b0;
      sck_sync    <= 1'b0;
      sck_prev    <= 1'b0;
      sda_meta    <= 1'b1;
      sda_sync    <= 1'b1;
      sda_prev    <= 1'b1;
      sda_drive   <= 1'b0;
      busy        <= 1'b0;
      last_cmd    <= 5'd0;
      frame_error <= 1'b0;
      status      <= 8'h00;
      shift       <= 8'h00;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 2'd0;
      last_byte   <= 2'd0;
      phase       <= 1'b0;
      timer       <= '0;
      crc         <= 8'h00;
      word        <= 16'h0000;
      tx_shift    <= 24'h0;
      cmd_code    <= 5'd0;
      conn_cnt    <= 4'd0;
    end else begin
      sck_meta    <= bus.sck;
      sck_sync    <= sck_meta;
      sck_prev    <= sck_sync;
      sda_meta    <= bus.sda_in;
      sda_sync    <= sda_meta;
      sda_prev    <= sda_sync;
      frame_error <= 1'b0;

      if (sck_rise) begin
        if (sda_sync && !sda_drive) conn_cnt <= (conn_cnt == 4'd9) ? conn_cnt : conn_cnt + 4'd1;
        else                        conn_cnt <= 4'd0;
      end

      if (conn_hit && state != MEAS && state != SRST) begin
        state     <= IDLE;
        sda_drive <= 1'b0;
      end else begin
        case (state)
          IDLE: if (sda_fall && sck_sync) state <= ST1;
          ST1: begin
            if (sck_fall)      state <= ST2;
            else if (sda_rise) state <= IDLE;
          end
          ST2: begin
            if (sck_rise)                  state <= ST3;
            else if (sda_rise || sda_fall) state <= IDLE;
          end
          ST3: begin
            if (sda_rise) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
            end else if (sck_fall) begin
              state <= IDLE;
            end
          end
          CMD: if (sck_rise) begin
            shift   <= cmd_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (cmd_ok) begin
                cmd_code <= cmd_byte[4:0];
                crc      <= crc8(crc_init, cmd_byte);
                phase    <= 1'b0;
                state    <= CMD_ACK;
              end else begin
                frame_error <= 1'b1;
                state       <= IDLE;
              end
            end
          end
          CMD_ACK: if (sck_fall) begin
            if (!phase) begin
              sda_drive <= 1'b1;
              last_cmd  <= cmd_code;
              busy      <= (cmd_code != CMD_STAT);
              phase     <= 1'b1;
            end else begin
              sda_drive <= 1'b0;
              if (cmd_code == CMD_STAT) begin
                state <= READY;
              end else if (cmd_code == CMD_SRST) begin
                timer <= TW'(SRST_CYCLES);
                state <= SRST;
              end else begin
                timer <= TW'(MEAS_CYCLES);
                state <= MEAS;
              end
            end
          end
          MEAS: begin
            if (timer <= TW'(1)) begin
              word  <= (cmd_code == CMD_TEMP) ? {2'b00, temp_value} : {4'h0, rh_value};
              busy  <= 1'b0;
              state <= READY;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          SRST: begin
            if (timer <= TW'(1)) begin
              status <= 8'h00;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          READY: begin
            if (cmd_code == CMD_STAT) begin
              tx_shift  <= {status, rev8(crc_stat), 8'h00};
              last_byte <= 2'd1;
              sda_drive <= ~status[7];
            end else begin
              tx_shift  <= {word, rev8(crc_word)};
              last_byte <= 2'd2;
              sda_drive <= ~word[15];
            end
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            state    <= TX;
          end
          TX: begin
            if (abort_start) begin
              state <= ST1;
            end else if (sck_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_drive <= 1'b0;
                phase     <= 1'b0;
                state     <= M_ACK;
              end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                sda_drive <= ~tx_shift[22];
                tx_shift  <= tx_shift << 1;
              end
            end
          end
          M_ACK: begin
            if (abort_start) begin
              state <= ST1;
            end else if (sck_rise) begin
              if (sda_sync || byte_cnt == last_byte) state <= IDLE;
              else                                   phase <= 1'b1;
            end else if (sck_fall && phase) begin
              byte_cnt  <= byte_cnt + 2'd1;
              bit_cnt   <= 3'd0;
              sda_drive <= ~tx_shift[22];
              tx_shift  <= tx_shift << 1;
              state     <= TX;
            end
          end
          default: begin
            state     <= IDLE;
            sda_drive <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sht10_slave_emulator.sv
// Directed bench for sht10_slave_emulator: vector table of command transactions plus
// hand-written soft-reset, abort and mid-transfer reset sequences.
module tb_sht10_slave_emulator;
  localparam int MEAS = 50;
  localparam int SRST = 1100;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck_drv = 1'b0;
  logic        sda_drv = 1'b1;
  logic [13:0] temp_value = 14'h0;
  logic [11:0] rh_value = 12'h0;
  logic        busy;
  logic [4:0]  last_cmd;
  logic        frame_error;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt = 0;
  int oe_cnt = 0;

  always #5 clk = ~clk;

  sht10_if bus ();
  assign bus.sck    = sck_drv;
  assign bus.sda_in = sda_drv & ~bus.sda_out_en;

  sht10_slave_emulator #(.ADDR(3'b000), .MEAS_CYCLES(MEAS), .SRST_CYCLES(SRST)) dut (
    .clock      (clk),
    .reset      (reset),
    .bus        (bus),
    .temp_value (temp_value),
    .rh_value   (rh_value),
    .busy       (busy),
    .last_cmd   (last_cmd),
    .frame_error(frame_error)
  );

  always @(negedge clk) begin
    if (frame_error === 1'b1) fe_cnt++;
    if (bus.sda_out_en === 1'b1) oe_cnt++;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [13:0] temp;
    logic [11:0] rh;
    int          nread;
    logic        ack_line;
    int          exp_fe;
    logic [4:0]  exp_last;
    logic [23:0] eb;
  } vec_t;

  vec_t vecs[7];

  // Augmented-message polynomial division, independent of the shift-register form.
  function automatic logic [7:0] crc_model(input logic [23:0] msg);
    logic [31:0] m;
    m = {msg, 8'h00};
    for (int i = 31; i >= 8; i--)
      if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h131;
    return m[7:0];
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    repeat (HALF) tick();
  endtask

  task automatic clock_bit(input logic d, output logic s);
    sda_drv = d;
    half();
    sck_drv = 1'b1;
    repeat (HALF/2) tick();
    s = bus.sda_in;
    repeat (HALF/2) tick();
    sck_drv = 1'b0;
  endtask

  task automatic start_seq();
    sda_drv = 1'b1; sck_drv = 1'b0; half();
    sck_drv = 1'b1; half();
    sda_drv = 1'b0; half();
    sck_drv = 1'b0; half();
    sck_drv = 1'b1; half();
    sda_drv = 1'b1; half();
    sck_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_val, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(ack_val, s);
    sda_drv = 1'b1;
  endtask

  task automatic wait_data(input string tag);
    int k;
    int n;
    k = 0;
    while (bus.sda_in === 1'b0 && k < 20) begin tick(); k++; end
    n = 0;
    while (bus.sda_in === 1'b1 && n < MEAS + 100) begin tick(); n++; end
    check_rng({tag, " conv_time"}, n, MEAS - 1, MEAS + 3);
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    int         fe0;
    int         oe0;
    logic       a;
    logic [7:0] b;
    temp_value = v.temp;
    rh_value   = v.rh;
    fe0 = fe_cnt;
    oe0 = oe_cnt;
    start_seq();
    send_byte(v.cmd, a);
    check({tag, " ack_line"}, a, v.ack_line);
    check({tag, " last_cmd"}, last_cmd, v.exp_last);
    if (!v.ack_line && (v.cmd[4:0] == 5'b00011 || v.cmd[4:0] == 5'b00101)) begin
      check({tag, " busy_after_ack"}, busy, 1'b1);
      wait_data(tag);
      check({tag, " busy_done"}, busy, 1'b0);
    end
    for (int k = 0; k < v.nread; k++) begin
      read_byte(k == v.nread - 1, b);
      check($sformatf("%s byte%0d", tag, k), b, v.eb[(23 - 8*k) -: 8]);
    end
    repeat (4) tick();
    check({tag, " released"}, bus.sda_out_en, 1'b0);
    check({tag, " frame_error_cycles"}, fe_cnt - fe0, v.exp_fe);
    if (v.exp_fe != 0) check({tag, " data_high"}, oe_cnt - oe0, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       a;
    logic       s;
    logic [7:0] b;
    logic [2:0] bits;
    int         n;

    vecs[0] = '{8'h03, 14'h1A2B, 12'h000, 3, 1'b0, 0, 5'b00011,
                {8'h1A, 8'h2B, rev8(crc_model({8'h03, 8'h1A, 8'h2B}))}};
    vecs[1] = '{8'h05, 14'h0000, 12'h931, 2, 1'b0, 0, 5'b00101, {8'h09, 8'h31, 8'h00}};
    vecs[2] = '{8'h47, 14'h0000, 12'h000, 0, 1'b1, 1, 5'b00101, 24'h0};
    vecs[3] = '{8'h1F, 14'h0000, 12'h000, 0, 1'b1, 1, 5'b00101, 24'h0};
    vecs[4] = '{8'h07, 14'h0000, 12'h000, 2, 1'b0, 0, 5'b00111,
                {8'h00, rev8(crc_model({8'h00, 8'h07, 8'h00})), 8'h00}};
    vecs[5] = '{8'h05, 14'h0000, 12'hABC, 3, 1'b0, 0, 5'b00101,
                {8'h0A, 8'hBC, rev8(crc_model({8'h05, 8'h0A, 8'hBC}))}};
    vecs[6] = '{8'h03, 14'h3FFF, 12'h000, 1, 1'b0, 0, 5'b00011, {8'h3F, 8'h00, 8'h00}};

    repeat (3) tick();
    check("reset sda_out_en", bus.sda_out_en, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset last_cmd", last_cmd, 5'd0);
    check("reset frame_error", frame_error, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 7; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

    // soft reset, then status read must come back with a zero-seeded CRC
    start_seq();
    send_byte(8'h1E, a);
    check("srst ack_line", a, 1'b0);
    check("srst last_cmd", last_cmd, 5'b11110);
    check("srst busy", busy, 1'b1);
    repeat (5) tick();
    check("srst released", bus.sda_out_en, 1'b0);
    n = 5;
    while (busy === 1'b1 && n < SRST + 100) begin tick(); n++; end
    check_rng("srst busy_time", n, SRST, SRST + 5);
    do_txn("status_after_srst", vecs[4]);

    // abort mid-LSB with nine released SCK pulses
    temp_value = 14'h1A2B;
    start_seq();
    send_byte(8'h03, a);
    check("abort ack_line", a, 1'b0);
    wait_data("abort");
    read_byte(1'b0, b);
    check("abort msb", b, 8'h1A);
    for (int i = 2; i >= 0; i--) begin
      clock_bit(1'b1, s);
      bits[i] = s;
    end
    check("abort lsb_head", bits, 3'b001);
    for (int i = 0; i < 9; i++) clock_bit(1'b1, s);
    repeat (4) tick();
    check("abort released", bus.sda_out_en, 1'b0);
    do_txn("after_abort", vecs[0]);

    // synchronous reset while the MSB is being shifted out
    start_seq();
    send_byte(8'h03, a);
    check("rst_tx ack_line", a, 1'b0);
    wait_data("rst_tx");
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    repeat (4) tick();
    check("rst_tx driving", bus.sda_out_en, 1'b1);
    reset = 1'b1;
    tick();
    check("rst_tx sda_out_en", bus.sda_out_en, 1'b0);
    check("rst_tx busy", busy, 1'b0);
    check("rst_tx last_cmd", last_cmd, 5'd0);
    check("rst_tx frame_error", frame_error, 1'b0);
    reset = 1'b0;
    repeat (4) tick();
    do_txn("after_reset", vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
